// File: rtl/score_bcd_digits.sv
// Binary score to four BCD digits by sequential double-dabble, with results
// staged and committed only on frame_start_in so renderers never see a torn value.
module score_bcd_digits #(
  parameter int SCORE_WIDTH = 14,
  parameter int MAX_SCORE   = 9999
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic [SCORE_WIDTH-1:0] score_in,
  input  logic                   start_in,
  input  logic                   frame_start_in,
  output logic [15:0]            digits_out,
  output logic [3:0]             blank_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam int CNT_W = $clog2(SCORE_WIDTH + 1);
  localparam logic [SCORE_WIDTH-1:0] MAX_VAL   = SCORE_WIDTH'(MAX_SCORE);
  localparam logic [CNT_W-1:0]       LAST_ITER = CNT_W'(SCORE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STAGE
  } state_t;

  state_t                 state_q, state_d;
  logic [SCORE_WIDTH-1:0] bin_q, bin_d;
  logic [15:0]            bcd_q, bcd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic [SCORE_WIDTH-1:0] pend_score_q, pend_score_d;
  logic [15:0]            stage_q, stage_d;
  logic                   result_ready_q, result_ready_d;
  logic [15:0]            digits_q, digits_d;
  logic [3:0]             blank_q, blank_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   commit;

  function automatic logic [SCORE_WIDTH-1:0] saturate(input logic [SCORE_WIDTH-1:0] s);
    return (s > MAX_VAL) ? MAX_VAL : s;
  endfunction

  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A digit blanks only when it and every more significant digit are zero;
  // the ones digit is always drawn so a score of 0 still shows "0".
  function automatic logic [3:0] blank_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

  always_comb begin
    state_d        = state_q;
    bin_d          = bin_q;
    bcd_d          = bcd_q;
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    pend_score_d   = pend_score_q;
    stage_d        = stage_q;
    result_ready_d = result_ready_q;
    digits_d       = digits_q;
    blank_d        = blank_q;
    done_d         = 1'b0;
    commit         = result_ready_q && frame_start_in;

    if (commit) begin
      digits_d       = stage_q;
      blank_d        = blank_mask(stage_q);
      result_ready_d = 1'b0;
      done_d         = 1'b1;
    end

    // Requests arriving mid-conversion (including on the STAGE edge) queue here.
    if (start_in && state_q != IDLE) begin
      pending_d    = 1'b1;
      pend_score_d = score_in;
    end

    case (state_q)
      IDLE: begin
        if (start_in || pending_q) begin
          state_d   = SHIFT;
          bin_d     = saturate(start_in ? score_in : pend_score_q);
          bcd_d     = 16'h0000;
          cnt_d     = '0;
          pending_d = 1'b0;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = STAGE;
      end
      STAGE: begin
        stage_d        = bcd_q;
        result_ready_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      bin_q          <= '0;
      bcd_q          <= 16'h0000;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      pend_score_q   <= '0;
      stage_q        <= 16'h0000;
      result_ready_q <= 1'b0;
      digits_q       <= 16'h0000;
      blank_q        <= 4'b1110;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bin_q          <= bin_d;
      bcd_q          <= bcd_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      pend_score_q   <= pend_score_d;
      stage_q        <= stage_d;
      result_ready_q <= result_ready_d;
      digits_q       <= digits_d;
      blank_q        <= blank_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign digits_out = digits_q;
  assign blank_out  = blank_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;

endmodule
